// File: rtl/operand_fetch_if.sv
// Decode-to-fetch and fetch-to-execute handshake bundle for operand_fetch.
// The fetch block is the slave; the decode/execute side is the master.
interface operand_fetch_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [4:0]      in_rd_addr;
  logic            in_rd_wen;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [4:0]      out_rd_addr;
  logic            out_rd_wen;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wen, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_wen
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wen, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_wen
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: busy scoreboard, writeback bypass and one-entry output buffer.
// Optional macro STALL_COUNT_EN adds a saturating 32-bit hazard stall counter port.
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  io,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic [NREG-1:0] busy_mask
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            out_valid_q;
  logic [XLEN-1:0] out_rs1_q;
  logic [XLEN-1:0] out_rs2_q;
  logic [4:0]      out_rd_addr_q;
  logic            out_rd_wen_q;

  logic            wb_live;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            wb_hit_rd;
  logic            avail_rs1;
  logic            avail_rs2;
  logic            rd_hazard;
  logic            hazard;
  logic            in_ready_int;
  logic            accept;
  logic [XLEN-1:0] op_rs1;
  logic [XLEN-1:0] op_rs2;

  assign rf_rs1_addr = io.in_rs1_addr;
  assign rf_rs2_addr = io.in_rs2_addr;

  // Writebacks to x0 never bypass and never touch the scoreboard.
  assign wb_live    = wb_valid && (wb_rd_addr != 5'd0);
  assign wb_hit_rs1 = wb_live && (wb_rd_addr == io.in_rs1_addr);
  assign wb_hit_rs2 = wb_live && (wb_rd_addr == io.in_rs2_addr);
  assign wb_hit_rd  = wb_live && (wb_rd_addr == io.in_rd_addr);

  assign avail_rs1 = (io.in_rs1_addr == 5'd0) || !busy_q[io.in_rs1_addr] || wb_hit_rs1;
  assign avail_rs2 = (io.in_rs2_addr == 5'd0) || !busy_q[io.in_rs2_addr] || wb_hit_rs2;
  assign rd_hazard = io.in_rd_wen && (io.in_rd_addr != 5'd0) &&
                     busy_q[io.in_rd_addr] && !wb_hit_rd;
  assign hazard    = !avail_rs1 || !avail_rs2 || rd_hazard;

  assign in_ready_int = !hazard && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && in_ready_int;
  assign io.in_ready  = in_ready_int;

  always_comb begin
    op_rs1 = rf_rs1_data;
    op_rs2 = rf_rs2_data;
    if (io.in_rs1_addr == 5'd0) begin
      op_rs1 = '0;
    end else if (wb_hit_rs1) begin
      op_rs1 = wb_rd_data;
    end
    if (io.in_rs2_addr == 5'd0) begin
      op_rs2 = '0;
    end else if (wb_hit_rs2) begin
      op_rs2 = wb_rd_data;
    end
  end

  // A set from a new accept overrides a same-cycle writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) begin
      busy_d[wb_rd_addr] = 1'b0;
    end
    if (accept && io.in_rd_wen && (io.in_rd_addr != 5'd0)) begin
      busy_d[io.in_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_rd_addr_q <= '0;
      out_rd_wen_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_rs1_q     <= op_rs1;
      out_rs2_q     <= op_rs2;
      out_rd_addr_q <= io.in_rd_addr;
      out_rd_wen_q  <= io.in_rd_wen;
    end else if (io.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.out_rs1_data = out_rs1_q;
  assign io.out_rs2_data = out_rs2_q;
  assign io.out_rd_addr  = out_rd_addr_q;
  assign io.out_rd_wen   = out_rd_wen_q;
  assign busy_mask       = busy_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (io.in_valid && hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized self-checking bench for operand_fetch against a scoreboard-level model.
// Build with +define+STALL_COUNT_EN to also check the stall counter.
module tb_operand_fetch;
  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk;
  logic            rst;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic            wb_valid;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  logic [NREG-1:0] busy_mask;
`ifdef STALL_COUNT_EN
  logic [31:0]     stall_count;
  longint unsigned m_stalls;
`endif

  operand_fetch_if #(.XLEN(XLEN)) bus ();

  operand_fetch #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus.slave),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_data  (wb_rd_data),
    .busy_mask   (busy_mask)
`ifdef STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file contents seen by the block; entry 0 is deliberately left nonzero.
  logic [XLEN-1:0] rf_mem [NREG];
  assign rf_rs1_data = rf_mem[rf_rs1_addr];
  assign rf_rs2_data = rf_mem[rf_rs2_addr];

  // Reference model: set of in-flight destinations plus the buffered output entry.
  bit              m_busy [NREG];
  bit              m_ov;
  logic [XLEN-1:0] m_o1;
  logic [XLEN-1:0] m_o2;
  logic [4:0]      m_rd;
  logic            m_wen;

  int n_cmp;
  int n_bad;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] modelMask();
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 1; i < NREG; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_ov  = 1'b0;
    m_o1  = '0;
    m_o2  = '0;
    m_rd  = '0;
    m_wen = 1'b0;
`ifdef STALL_COUNT_EN
    m_stalls = 0;
`endif
  endtask

  function automatic logic [XLEN-1:0] expOperand(input logic [4:0] rs, input logic wv,
                                                 input logic [4:0] wa, input logic [XLEN-1:0] wd);
    if (rs == 5'd0) return '0;
    if (wv && wa == rs) return wd;
    return rf_mem[rs];
  endfunction

  // One cycle: drive at negedge, check ready before the edge, check state after it.
  task automatic applyStimulus(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] d, input logic w, input logic ordy,
                               input logic wv, input logic [4:0] wa, input logic [XLEN-1:0] wd);
    bit ok1, ok2, rdh, haz, exp_ready, acc;
    logic [XLEN-1:0] e1, e2;
    @(negedge clk);
    bus.in_valid    = v;
    bus.in_rs1_addr = a1;
    bus.in_rs2_addr = a2;
    bus.in_rd_addr  = d;
    bus.in_rd_wen   = w;
    bus.out_ready   = ordy;
    wb_valid        = wv;
    wb_rd_addr      = wa;
    wb_rd_data      = wd;
    #1;
    ok1 = (a1 == 0) || !m_busy[a1] || (wv && wa == a1);
    ok2 = (a2 == 0) || !m_busy[a2] || (wv && wa == a2);
    rdh = w && (d != 0) && m_busy[d] && !(wv && wa == d);
    haz = !ok1 || !ok2 || rdh;
    exp_ready = !haz && (!m_ov || ordy);
    acc = v && exp_ready;
    e1 = expOperand(a1, wv, wa, wd);
    e2 = expOperand(a2, wv, wa, wd);
    checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
    checkOutput("rf_rs1_addr", {59'd0, rf_rs1_addr}, {59'd0, a1});
    checkOutput("rf_rs2_addr", {59'd0, rf_rs2_addr}, {59'd0, a2});
    @(posedge clk);
    #1;
    if (acc) begin
      m_ov  = 1'b1;
      m_o1  = e1;
      m_o2  = e2;
      m_rd  = d;
      m_wen = w;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (wv && wa != 0) m_busy[wa] = 1'b0;
    if (acc && w && d != 0) m_busy[d] = 1'b1;
    if (wv && wa != 0) rf_mem[wa] = wd;
`ifdef STALL_COUNT_EN
    if (v && haz && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    checkOutput("stall_count", {32'd0, stall_count}, m_stalls);
`endif
    checkOutput("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
    checkOutput("out_rs1_data", bus.out_rs1_data, m_o1);
    checkOutput("out_rs2_data", bus.out_rs2_data, m_o2);
    checkOutput("out_rd_addr", {59'd0, bus.out_rd_addr}, {59'd0, m_rd});
    checkOutput("out_rd_wen", {63'd0, bus.out_rd_wen}, {63'd0, m_wen});
    checkOutput("busy_mask", {32'd0, busy_mask}, {32'd0, modelMask()});
  endtask

  logic [XLEN-1:0] held1;
  logic [XLEN-1:0] held2;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rs1_addr = '0;
    bus.in_rs2_addr = '0;
    bus.in_rd_addr = '0;
    bus.in_rd_wen = 1'b0;
    bus.out_ready = 1'b0;
    wb_valid = 1'b0;
    wb_rd_addr = '0;
    wb_rd_data = '0;
    for (int i = 0; i < NREG; i++) rf_mem[i] = {$urandom, $urandom};
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_busy_mask", {32'd0, busy_mask}, 64'd0);
    checkOutput("reset_out_rs1", bus.out_rs1_data, 64'd0);
    checkOutput("reset_out_rd_wen", {63'd0, bus.out_rd_wen}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plan 1: plain accept.
    rf_mem[1] = 64'd1;
    rf_mem[2] = 64'd13;
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 64'd0);
    checkOutput("tp1_rs1", bus.out_rs1_data, 64'd1);
    checkOutput("tp1_rs2", bus.out_rs2_data, 64'd13);
    checkOutput("tp1_busy", {32'd0, busy_mask}, 64'h8);

    // Plan 2: RAW stall, then release by same-cycle writeback with bypass.
    applyStimulus(1, 5'd3, 5'd0, 5'd4, 0, 1, 0, 5'd0, 64'd0);
    checkOutput("tp2_stall_valid", {63'd0, bus.out_valid}, 64'd0);
    applyStimulus(1, 5'd3, 5'd0, 5'd4, 0, 1, 1, 5'd3, 64'h55);
    checkOutput("tp2_bypass", bus.out_rs1_data, 64'h55);
    checkOutput("tp2_busy", {32'd0, busy_mask}, 64'h0);

    // Plan 3: x0 sources read as zero; writeback to x0 ignored.
    rf_mem[0] = 64'hFFFF;
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 64'd9);
    checkOutput("tp3_rs1", bus.out_rs1_data, 64'd0);
    checkOutput("tp3_rs2", bus.out_rs2_data, 64'd0);
    checkOutput("tp3_busy", {32'd0, busy_mask}, 64'h0);

    // Plan 4: backpressure holds the buffer, then back-to-back accept.
    rf_mem[6] = 64'hABCD;
    applyStimulus(1, 5'd6, 5'd1, 5'd7, 0, 1, 0, 5'd0, 64'd0);
    held1 = bus.out_rs1_data;
    held2 = bus.out_rs2_data;
    checkOutput("tp4_first", held1, 64'hABCD);
    repeat (3) applyStimulus(1, 5'd2, 5'd1, 5'd7, 0, 0, 0, 5'd0, 64'd0);
    checkOutput("tp4_hold_rs1", bus.out_rs1_data, 64'hABCD);
    checkOutput("tp4_hold_rs2", bus.out_rs2_data, 64'd1);
    applyStimulus(1, 5'd2, 5'd1, 5'd7, 0, 1, 0, 5'd0, 64'd0);
    checkOutput("tp4_next", bus.out_rs1_data, 64'd13);

    // Plan 5: set wins over same-cycle clear.
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 5'd0, 64'd0);
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 1, 1, 5'd5, 64'd77);
    checkOutput("tp5_busy", {32'd0, busy_mask}, 64'h20);

    // Plan 6: async reset with a buffered entry and busy 0x28.
    applyStimulus(1, 5'd0, 5'd0, 5'd3, 1, 1, 0, 5'd0, 64'd0);
    checkOutput("tp6_busy_pre", {32'd0, busy_mask}, 64'h28);
    checkOutput("tp6_valid_pre", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("tp6_valid_async", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("tp6_busy_async", {32'd0, busy_mask}, 64'd0);
    checkOutput("tp6_rd_async", {59'd0, bus.out_rd_addr}, 64'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic over a small register window to provoke hazards.
    rf_mem[0] = {$urandom, $urandom};
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] wa;
      logic       wv;
      int         pend [$];
      pend.delete();
      for (int i = 1; i < NREG; i++) if (m_busy[i]) pend.push_back(i);
      wv = ($urandom_range(0, 9) < 5);
      if (pend.size() > 0 && $urandom_range(0, 9) < 7)
        wa = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wa = 5'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, wv, wa, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side client of the 32 x 64-bit register file.
- Accepts decoded source/destination register indices over a valid/ready handshake and drives the register file read addresses.
- Resolves RAW/WAW hazards with a per-register busy scoreboard and bypasses same-cycle writeback data.
- Presents registered operands to the execute stage one cycle later, with a one-entry output buffer.

Parameters:
XLEN, 64, operand/data width in bits
NREG, 32, number of architectural registers; index width is 5 bits, fixed for NREG=32

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decoded instruction available
in_ready  output  1  block accepts instruction this cycle
in_rs1_addr  input  5  source register 1 index
in_rs2_addr  input  5  source register 2 index
in_rd_addr  input  5  destination register index
in_rd_wen  input  1  instruction will write rd
rf_rs1_addr  output  5  register file read address 1; equals in_rs1_addr, combinational
rf_rs2_addr  output  5  register file read address 2; equals in_rs2_addr, combinational
rf_rs1_data  input  XLEN  register file read data 1, combinational
rf_rs2_data  input  XLEN  register file read data 2, combinational
wb_valid  input  1  writeback this cycle; same signal that drives register file reg_write
wb_rd_addr  input  5  writeback destination index
wb_rd_data  input  XLEN  writeback data
out_valid  output  1  registered operands valid
out_ready  input  1  execute stage consumes operands
out_rs1_data  output  XLEN  operand 1
out_rs2_data  output  XLEN  operand 2
out_rd_addr  output  5  destination index, passed through
out_rd_wen  output  1  destination write enable, passed through
busy_mask  output  NREG  scoreboard state; bit 0 always 0

Behaviour:
- Reset (async): out_valid=0; out_* data, addr and wen = 0; busy_mask=0. Asserting reset mid-operation drops the buffered entry and all pending busy bits.
- Source available: rs==0, OR busy[rs]==0, OR (wb_valid && wb_rd_addr==rs).
- hazard = !avail(rs1) || !avail(rs2) || (in_rd_wen && in_rd_addr!=0 && busy[in_rd_addr] && !(wb_valid && wb_rd_addr==in_rd_addr)).
- in_ready = !hazard && (!out_valid || out_ready). in_ready is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready.
- On accept, next edge:
  - out_valid=1.
  - Operand per source: 0 if rs==0; else wb_rd_data if wb_valid && wb_rd_addr==rs; else rf_rsN_data.
  - out_rd_addr and out_rd_wen captured from inputs.
- Latency: exactly 1 cycle from accept to out_valid.
- No accept and out_ready=1: out_valid -> 0.
- out_valid=1 and out_ready=0: all out_* held stable; in_ready=0.
- Scoreboard update per edge:
  - wb_valid with wb_rd_addr!=0 clears busy[wb_rd_addr].
  - Accept with in_rd_wen and in_rd_addr!=0 sets busy[in_rd_addr].
  - Set and clear of the same index in one cycle: set wins.
- wb_valid with wb_rd_addr=0: ignored for both bypass and scoreboard.
- in_rd_wen=1 with in_rd_addr=0: no busy bit set; rd fields still passed through.
- Writeback to a non-busy register: clear is a no-op. Bypass still applies, matching register file write-first semantics.

Optional Feature:
STALL_COUNT_EN
- Defined: adds output stall_count (32 bits). It increments on every cycle with in_valid && hazard, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then in rs1=1, rs2=2, rd=3, wen=1 with rf data 1 and 13, out_ready=1 -> next cycle out_valid=1, out_rs1=1, out_rs2=13, busy_mask=0x8.
2. busy[3] set, then in rs1=3 -> in_ready=0 with out_valid clearing. Then wb_valid rd=3 data 0x55 in the same cycle -> accepted, out_rs1=0x55, busy[3] cleared.
3. rs1=0, rs2=0 with rf data driven to 0xFFFF -> out_rs1=out_rs2=0. wb_valid rd=0 data 9 -> busy_mask unchanged, no bypass.
4. out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_* held. Then out_ready=1 with a new in_valid -> back-to-back accept, out updates next edge.
5. Accept rd=5 wen=1 in the same cycle as wb_valid rd=5 -> busy[5]=1 afterward (set wins).
6. Assert rst asynchronously while out_valid=1 and busy_mask=0x28 -> out_valid=0 and busy_mask=0 immediately, before the next clock edge.
